sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 144 ++++++++++++++
 tb/tb_sram_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// SRAM controller: fills a 64-bit cache line from a 16-bit external SRAM
// (four halfword reads) and writes 32-bit words through as two halfwords.
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [63:0] SRAM_read_data,
  output logic        SRAM_ready,
  output logic        freeze,
  output logic [17:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_BASE = 1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    WR0  = 3'd5,
    WR1  = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [ADDR_W-1:0]  da;
  logic               req;
  logic               unused_da_bits;

  // Offset into the data region; only bits [18:2] address the SRAM.
  assign da             = addr_q - ADDR_W'(DATA_BASE);
  assign unused_da_bits = ^{da[31:19], da[1:0]};
  assign req            = MEM_R_EN | MEM_W_EN;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; reads take priority over writes on acceptance.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (MEM_R_EN) begin
          state_nxt = RD0;
        end else if (MEM_W_EN) begin
          state_nxt = WR0;
        end
      end
      RD0:     state_nxt = RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = RD3;
      RD3:     state_nxt = DONE;
      WR0:     state_nxt = WR1;
      WR1:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; the SRAM bus idles at address 0, not driven, strobe high.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_ready  = 1'b0;
    freeze      = 1'b0;
    unique case (state)
      IDLE: freeze = req;
      RD0: begin
        freeze    = 1'b1;
        SRAM_ADDR = {da[18:3], 2'd0};
      end
      RD1: begin
        freeze    = 1'b1;
        SRAM_ADDR = {da[18:3], 2'd1};
      end
      RD2: begin
        freeze    = 1'b1;
        SRAM_ADDR = {da[18:3], 2'd2};
      end
      RD3: begin
        freeze    = 1'b1;
        SRAM_ADDR = {da[18:3], 2'd3};
      end
      WR0: begin
        freeze      = 1'b1;
        SRAM_ADDR   = {da[18:2], 1'b0};
        SRAM_DQ_out = wdata_q[15:0];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      WR1: begin
        freeze      = 1'b1;
        SRAM_ADDR   = {da[18:2], 1'b1};
        SRAM_DQ_out = wdata_q[31:16];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      DONE:    SRAM_ready = 1'b1;
      default: ;
    endcase
  end

  // Request latch and line assembly from the four captured halfwords.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      SRAM_read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= address;
        wdata_q <= write_data;
      end
      unique case (state)
        RD0:     SRAM_read_data[47:32] <= SRAM_DQ_in;
        RD1:     SRAM_read_data[63:48] <= SRAM_DQ_in;
        RD2:     SRAM_read_data[15:0]  <= SRAM_DQ_in;
        RD3:     SRAM_read_data[31:16] <= SRAM_DQ_in;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed scenarios plus random traffic against a
// transaction-level memory model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [63:0] SRAM_read_data;
  logic        SRAM_ready;
  logic        freeze;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  int checks = 0;
  int errors = 0;

  // sram: the external device, driven only by the DUT pins.
  // ref_mem: the expected memory contents, updated per completed transaction.
  logic [15:0] sram    [logic [17:0]];
  logic [15:0] ref_mem [logic [17:0]];
  logic [63:0] last_line;

  sram_controller dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_R_EN       (MEM_R_EN),
    .MEM_W_EN       (MEM_W_EN),
    .address        (address),
    .write_data     (write_data),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_ready     (SRAM_ready),
    .freeze         (freeze),
    .SRAM_ADDR      (SRAM_ADDR),
    .SRAM_DQ_in     (SRAM_DQ_in),
    .SRAM_DQ_out    (SRAM_DQ_out),
    .SRAM_DQ_oe     (SRAM_DQ_oe),
    .SRAM_WE_N      (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end expected end before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] fill(input logic [17:0] a);
    return 16'(32'(a) * 32'd40503) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] dev_rd(input logic [17:0] a);
    if (sram.exists(a)) return sram[a];
    return fill(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  // Halfword index of the line base / word for a byte address.
  function automatic logic [17:0] line_hw(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return 18'(((off % 32'h80000) / 32'd8) * 32'd4);
  endfunction

  function automatic logic [17:0] word_hw(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return 18'(((off % 32'h80000) / 32'd4) * 32'd2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle mid-cycle, then act as the SRAM device.
  task automatic settle();
    #1;
    SRAM_DQ_in = dev_rd(SRAM_ADDR);
    if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR] = SRAM_DQ_out;
  endtask

  task automatic bus_idle(input string ph);
    chk({ph, "_we"}, 64'(SRAM_WE_N), 64'd1);
    chk({ph, "_oe"}, 64'(SRAM_DQ_oe), 64'd0);
    chk({ph, "_dq"}, 64'(SRAM_DQ_out), 64'd0);
  endtask

  task automatic idle_check();
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    address = $urandom; write_data = $urandom;
    settle();
    chk("idle_ready", 64'(SRAM_ready), 64'd0);
    chk("idle_freeze", 64'(freeze), 64'd0);
    chk("idle_addr", 64'(SRAM_ADDR), 64'd0);
    bus_idle("idle");
    chk("idle_line_hold", SRAM_read_data, last_line);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input bit both, input bit hold);
    logic [17:0] h;
    logic [63:0] exp_line;
    h = line_hw(a);
    exp_line = {ref_rd(18'(h + 18'd1)), ref_rd(h), ref_rd(18'(h + 18'd3)), ref_rd(18'(h + 18'd2))};
    MEM_R_EN = 1'b1; MEM_W_EN = both; address = a; write_data = $urandom;
    settle();
    chk("rd_accept_freeze", 64'(freeze), 64'd1);
    chk("rd_accept_ready", 64'(SRAM_ready), 64'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      MEM_R_EN = hold ? 1'b1 : 1'($urandom);
      MEM_W_EN = 1'($urandom);
      address = $urandom; write_data = $urandom;
      settle();
      chk($sformatf("rd%0d_addr", k), 64'(SRAM_ADDR), 64'(18'(h + 18'(k))));
      chk($sformatf("rd%0d_freeze", k), 64'(freeze), 64'd1);
      chk($sformatf("rd%0d_ready", k), 64'(SRAM_ready), 64'd0);
      bus_idle("rd");
      @(negedge clk);
    end
    MEM_R_EN = hold; MEM_W_EN = 1'b0;
    settle();
    chk("rd_done_ready", 64'(SRAM_ready), 64'd1);
    chk("rd_done_freeze", 64'(freeze), 64'd0);
    chk("rd_done_addr", 64'(SRAM_ADDR), 64'd0);
    chk("rd_line", SRAM_read_data, exp_line);
    last_line = exp_line;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd);
    logic [17:0] w;
    w = word_hw(a);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; address = a; write_data = wd;
    settle();
    chk("wr_accept_freeze", 64'(freeze), 64'd1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      MEM_R_EN = 1'($urandom); MEM_W_EN = 1'($urandom);
      address = $urandom; write_data = $urandom;
      settle();
      chk($sformatf("wr%0d_addr", k), 64'(SRAM_ADDR), 64'(18'(w + 18'(k))));
      chk($sformatf("wr%0d_dq", k), 64'(SRAM_DQ_out), 64'(k == 0 ? wd[15:0] : wd[31:16]));
      chk($sformatf("wr%0d_we", k), 64'(SRAM_WE_N), 64'd0);
      chk($sformatf("wr%0d_oe", k), 64'(SRAM_DQ_oe), 64'd1);
      chk($sformatf("wr%0d_freeze", k), 64'(freeze), 64'd1);
      chk($sformatf("wr%0d_ready", k), 64'(SRAM_ready), 64'd0);
      @(negedge clk);
    end
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    settle();
    chk("wr_done_ready", 64'(SRAM_ready), 64'd1);
    chk("wr_done_freeze", 64'(freeze), 64'd0);
    chk("wr_line_kept", SRAM_read_data, last_line);
    bus_idle("wr_done");
    ref_mem[w] = wd[15:0];
    ref_mem[18'(w + 18'd1)] = wd[31:16];
    @(negedge clk);
  endtask

  task automatic post_reset_check(input string ph);
    settle();
    chk({ph, "_line"}, SRAM_read_data, 64'd0);
    chk({ph, "_ready"}, 64'(SRAM_ready), 64'd0);
    chk({ph, "_addr"}, 64'(SRAM_ADDR), 64'd0);
    chk({ph, "_freeze"}, 64'(freeze), 64'd0);
    bus_idle(ph);
    last_line = 64'd0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    address = '0; write_data = '0; SRAM_DQ_in = '0;
    last_line = '0;
    @(negedge clk);
    @(negedge clk);
    post_reset_check("reset");
    rst = 1'b1;
    idle_check();

    // Known line content at halfwords 4..7.
    sram[18'd4] = 16'h1111; sram[18'd5] = 16'h2222;
    sram[18'd6] = 16'h3333; sram[18'd7] = 16'h4444;
    ref_mem[18'd4] = 16'h1111; ref_mem[18'd5] = 16'h2222;
    ref_mem[18'd6] = 16'h3333; ref_mem[18'd7] = 16'h4444;
    do_read(32'd1032, 1'b0, 1'b0);
    chk("line_literal", SRAM_read_data, 64'h2222_1111_4444_3333);
    idle_check();

    // Unaligned read maps to the same line.
    do_read(32'd1036, 1'b0, 1'b0);
    chk("unaligned_literal", SRAM_read_data, 64'h2222_1111_4444_3333);
    idle_check();

    // Write-through of one word.
    do_write(32'd1028, 32'hDEADBEEF);
    chk("wr_dev_lo", 64'(dev_rd(18'd2)), 64'h0000_0000_0000_BEEF);
    chk("wr_dev_hi", 64'(dev_rd(18'd3)), 64'h0000_0000_0000_DEAD);
    chk("wr_line_literal", SRAM_read_data, 64'h2222_1111_4444_3333);
    idle_check();

    // Simultaneous requests: the read wins.
    do_read(32'd1024, 1'b1, 1'b0);
    idle_check();

    // Reset during RD2 aborts the fill.
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = 32'd1040;
    settle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      MEM_R_EN = 1'b0;
      if (k == 2) rst = 1'b0;
      settle();
      chk($sformatf("abort_rd%0d_addr", k), 64'(SRAM_ADDR), 64'(18'(line_hw(32'd1040) + 18'(k))));
      @(negedge clk);
    end
    rst = 1'b1;
    post_reset_check("abort_rd");
    for (int i = 0; i < 3; i++) idle_check();

    // Reset during WR0: only the low halfword reaches the SRAM.
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; address = 32'd1064; write_data = 32'hCAFE_F00D;
    settle();
    @(negedge clk);
    MEM_W_EN = 1'b0; rst = 1'b0;
    settle();
    chk("abort_wr_we", 64'(SRAM_WE_N), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    post_reset_check("abort_wr");
    ref_mem[word_hw(32'd1064)] = 16'hF00D;
    do_read(32'd1064, 1'b0, 1'b0);
    chk("abort_wr_hi_kept", 64'(dev_rd(18'(word_hw(32'd1064) + 18'd1))),
        64'(fill(18'(word_hw(32'd1064) + 18'd1))));
    idle_check();

    // Back-to-back reads with the request held through SRAM_ready.
    do_read(32'd1048, 1'b0, 1'b1);
    do_read(32'd1056, 1'b0, 1'b1);
    do_read(32'd1032, 1'b0, 1'b0);
    idle_check();

    // Wrapped addresses below the data region and beyond 2^18 bytes.
    do_write(32'd8, 32'h0BAD_CAFE);
    do_read(32'd8, 1'b0, 1'b0);
    do_read(32'hFFFF_FFF0, 1'b0, 1'b0);
    idle_check();

    // Random traffic over a small region so reads revisit written lines.
    for (int t = 0; t < 60; t++) begin
      a = ($urandom % 8 == 0) ? $urandom : 32'd1024 + ($urandom % 96);
      if ($urandom % 2 == 0) do_write(a, $urandom);
      else                   do_read(a, 1'($urandom), 1'b0);
      for (int i = 0; i < int'($urandom % 3); i++) idle_check();
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
